mul_div_unit: RTL
=================

# mul_div_unit

Iterative 8-bit unsigned multiply/divide unit on the datapath's single `ph1` clock. Consumes the two operand bytes read from the general-purpose register file. Produces a one-cycle write-back request (`RegWrite`, `Write_register`, `Write_data`) that drives the register file's write port directly. One operation is in flight at a time, taking a fixed 8 cycles of iteration.

## Interface
Parameters: none; data width is fixed at 8 bits and the register index at 5 bits, matching the register file.

- `ph1`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset synchronous active-high
- `start`  in  1  request a new operation; honoured only when `busy`=0
- `cancel`  in  1  abort the operation in flight; effective only in RUN
- `op`  in  2  00 MUL (product[7:0]), 01 MULH (product[15:8]), 10 DIVU (quotient), 11 REMU (remainder)
- `a`  in  8  operand A (multiplicand / dividend), unsigned
- `b`  in  8  operand B (multiplier / divisor), unsigned
- `dest`  in  5  destination register index, passed through unmodified
- `busy`  out  1  high in RUN and DONE
- `RegWrite`  out  1  write strobe to the register file, high for exactly one cycle per completed op
- `Write_register`  out  5  destination index, valid while `RegWrite`=1
- `Write_data`  out  8  result byte, valid while `RegWrite`=1
- `div_by_zero`  out  1  high with `RegWrite` when op is DIVU/REMU and captured `b`=0

## Operation
- The FSM has three states: IDLE, RUN and DONE. A 3-bit iteration counter runs in RUN.
- **IDLE → RUN:** taken on an edge with `start`=1.
  - Captures `op`, `a`, `b` and `dest` into internal registers.
  - Clears the counter, the 16-bit accumulator and the partial remainder.
  - Input changes after this capture edge have no effect on the op.
- **RUN, multiply (shift-add):** 8 iterations, one bit of B per edge, LSB first.
  - Each edge conditionally adds A to the accumulator, then shifts.
  - The result is the exact 16-bit product.
- **RUN, divide (restoring):** 8 iterations, one dividend bit per edge, MSB first.
  - Each edge computes R = {R[7:0], next A bit} with 9-bit compare/subtract.
  - Quotient bit is 1 if R ≥ B, in which case R ← R − B.
- **RUN → DONE:** taken on the edge where counter = 7 completes.
  - `Write_data`, `Write_register` and `div_by_zero` are registered on that edge.
  - `RegWrite`=1 for the whole DONE cycle.
- **DONE → IDLE:** unconditional on the next edge.
  - `RegWrite` returns to 0.
  - `Write_data`, `Write_register` and `div_by_zero` hold their last values until the next DONE.
- **Divide by zero:** falls out of the restoring algorithm; no special casing.
  - Quotient is 0xFF; remainder equals A.
  - `div_by_zero`=1 only for DIVU/REMU with `b`=0; it is 0 for MUL/MULH regardless of `b`.
- **`dest`=0:** the write is still issued. The register file discards writes to index 0.
- **`cancel`:**
  - In RUN: returns to IDLE on the next edge; no `RegWrite` is ever produced for that op.
  - In IDLE or DONE: ignored. A DONE write is already committed.
- **`start` with `busy`=1:** ignored, with no queuing.
- **`start` and `cancel` together in IDLE:** start is accepted.

## Timing
- **Reset values** (forced on any edge with `reset`=1, from any state): state IDLE, `busy`=0, `RegWrite`=0, `Write_register`=0, `Write_data`=0x00, `div_by_zero`=0, counter 0.
- **Reset priority:** reset overrides `start` and `cancel`. Reset mid-RUN or in DONE suppresses any further write pulse.
- **Edge numbering:** the accept edge is E0; iteration edges are E1–E8.
- **E8:** enters DONE, so `RegWrite` is high between E8 and E9. Accept-to-write latency is 8 cycles.
- **E9:** returns to IDLE, so `busy`=0 after E9.
- **Back-to-back:** the earliest next accept is E9+1 (E10). With `start` held high, writes pulse every 10 cycles.
- **Output registering:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **MUL:** MUL, a=13, b=11, dest=3 → `busy` rises after E0; exactly one `RegWrite` pulse after E8 with `Write_data`=0x8F, `Write_register`=3, `div_by_zero`=0.
- **MULH / MUL:** MULH a=0xFF, b=0xFF → `Write_data`=0xFE; MUL with the same operands → 0x01. Also MUL 0x00×0xAB → 0x00.
- **DIVU / REMU:** DIVU a=200, b=7 → 0x1C; REMU with the same operands → 0x04; DIVU a=5, b=9 → 0x00.
- **Divide by zero:** DIVU a=0x5A, b=0 → 0xFF with `div_by_zero`=1; REMU → 0x5A with `div_by_zero`=1.
- **Busy and back-to-back:**
  - Pulse `start` with new operands at E4 → ignored; the result reflects the E0 operands.
  - Hold `start` continuously → `RegWrite` pulses 10 cycles apart.
- **Abort:** `cancel` at iteration 4, or `reset` at iteration 4 → no `RegWrite` pulse, `busy`=0 on the next cycle.
  - After `reset`, all outputs are at their reset values.
  - A new op then completes normally.

Source files
------------

// File: rtl/mul_div_if.sv
// Operand/request and register-file write-back bundle for mul_div_unit.
// master = the issuing datapath, slave = the unit itself.
interface mul_div_if;
    // Handshake: start is honoured only on an edge where busy=0, with no queuing.
    // cancel aborts only while running. RegWrite is a one-cycle strobe, and
    // Write_register/Write_data/div_by_zero are valid while it is high.
    logic       start;
    logic       cancel;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] dest;
    logic       busy;
    logic       RegWrite;
    logic [4:0] Write_register;
    logic [7:0] Write_data;
    logic       div_by_zero;
    logic [1:0] state_dbg;

    modport master (
        output start, cancel, op, a, b, dest,
        input  busy, RegWrite, Write_register, Write_data, div_by_zero, state_dbg
    );

    modport slave (
        input  start, cancel, op, a, b, dest,
        output busy, RegWrite, Write_register, Write_data, div_by_zero, state_dbg
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 8-bit unsigned multiply (shift-add) / divide (restoring) unit.
// Each operation takes 8 iterations and ends in a one-cycle register-file write.
module mul_div_unit (
    input logic      ph1,
    input logic      reset,
    mul_div_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [4:0]  dest_q, dest_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [4:0]  wreg_q, wreg_d;
    logic        dbz_q, dbz_d;

    logic        is_div;
    logic [8:0]  mul_sum;
    logic [15:0] acc_step;
    logic [8:0]  div_trial;
    logic [8:0]  div_diff;
    logic        div_ge;
    logic [7:0]  rem_step;
    logic [7:0]  a_step;
    logic [7:0]  result;

    // One iteration of each algorithm. For divide, a_q doubles as the dividend
    // shifter and the quotient collector (quotient bits enter at the LSB).
    always_comb begin
        is_div    = op_q[1];
        mul_sum   = {1'b0, acc_q[15:8]} + (b_q[cnt_q] ? {1'b0, a_q} : 9'd0);
        acc_step  = {mul_sum, acc_q[7:1]};
        div_trial = {rem_q, a_q[7]};
        div_diff  = div_trial - {1'b0, b_q};
        div_ge    = (div_trial >= {1'b0, b_q});
        rem_step  = div_ge ? div_diff[7:0] : div_trial[7:0];
        a_step    = {a_q[6:0], div_ge};
        case (op_q)
            OP_MUL:  result = acc_step[7:0];
            OP_MULH: result = acc_step[15:8];
            OP_DIVU: result = a_step;
            OP_REMU: result = rem_step;
            default: result = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dest_d  = dest_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    dest_d  = bus.dest;
                    acc_d   = 16'h0000;
                    rem_d   = 8'h00;
                end
            end
            S_RUN: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div) begin
                        a_d   = a_step;
                        rem_d = rem_step;
                    end else begin
                        acc_d = acc_step;
                    end
                    cnt_d = cnt_q + 3'd1;
                    // Results are taken from this edge's step so DONE can present them at once.
                    if (cnt_q == 3'd7) begin
                        state_d = S_DONE;
                        wdata_d = result;
                        wreg_d  = dest_q;
                        dbz_d   = is_div && (b_q == 8'h00);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            op_q    <= 2'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            dest_q  <= 5'd0;
            acc_q   <= 16'h0000;
            rem_q   <= 8'h00;
            wdata_q <= 8'h00;
            wreg_q  <= 5'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.RegWrite       = (state_q == S_DONE);
    assign bus.Write_register = wreg_q;
    assign bus.Write_data     = wdata_q;
    assign bus.div_by_zero    = dbz_q;
    assign bus.state_dbg      = state_q;
endmodule
